// File: rtl/prog_updown_counter.sv
// Up/down counter with programmable step, runtime min/max limits and
// saturate / wrap / bounce handling at the limits.
module prog_updown_counter #(
   parameter int DATA_WIDTH = 8,
   parameter int STEP_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_in,
   input  logic                  i_up,
   input  logic                  i_down,
   input  logic [STEP_WIDTH-1:0] i_step,
   input  logic [DATA_WIDTH-1:0] i_min,
   input  logic [DATA_WIDTH-1:0] i_max,
   input  logic [1:0]            i_mode,
   output logic [DATA_WIDTH-1:0] o_counter,
   output logic                  o_high,
   output logic                  o_low,
   output logic                  o_wrap,
   output logic                  o_dir,
   output logic                  o_cfg_err
);

   localparam int W = DATA_WIDTH;
   localparam logic [1:0] MODE_WRAP   = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;

   logic [W-1:0] cnt_q, cnt_d;
   logic         dir_q, dir_d;
   logic         wrap_q, wrap_d;

   logic [W:0]   step_ext, nxt_up, nxt_dn;
   logic         up_over, up_reach, dn_under, dn_reach;
   logic         out_of_range, step_zero, bounce_up, turned;

   function automatic logic [W-1:0] clamp(input logic [W-1:0] v,
                                          input logic [W-1:0] lo,
                                          input logic [W-1:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

   // One extra bit keeps carry and borrow visible, so nothing wraps silently.
   assign step_ext = {{(W + 1 - STEP_WIDTH){1'b0}}, i_step};
   assign nxt_up   = {1'b0, cnt_q} + step_ext;
   assign nxt_dn   = {1'b0, cnt_q} - step_ext;
   assign up_over  = nxt_up >  {1'b0, i_max};
   assign up_reach = nxt_up >= {1'b0, i_max};
   assign dn_under = nxt_dn[W] | (nxt_dn[W-1:0] <  i_min);
   assign dn_reach = nxt_dn[W] | (nxt_dn[W-1:0] <= i_min);

   assign o_cfg_err    = i_min > i_max;
   assign out_of_range = (cnt_q < i_min) || (cnt_q > i_max);
   assign step_zero    = (i_step == '0);

   always_comb begin
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      wrap_d    = 1'b0;
      bounce_up = dir_q;
      turned    = 1'b0;
      if (o_cfg_err) begin
         cnt_d = cnt_q;
      end else if (i_load) begin
         cnt_d = clamp(i_in, i_min, i_max);
      end else if (i_en) begin
         if (out_of_range) begin
            cnt_d = clamp(cnt_q, i_min, i_max);
         end else if (i_min == i_max) begin
            if (i_mode == MODE_BOUNCE) begin
               dir_d  = ~dir_q;
               wrap_d = 1'b1;
            end
         end else if (!step_zero) begin
            case (i_mode)
               MODE_WRAP: begin
                  if (i_up) begin
                     cnt_d  = up_over ? i_min : nxt_up[W-1:0];
                     wrap_d = up_over;
                  end else if (i_down) begin
                     cnt_d  = dn_under ? i_max : nxt_dn[W-1:0];
                     wrap_d = dn_under;
                  end
               end
               MODE_BOUNCE: begin
                  // Sitting on the limit we are heading into: turn around first.
                  if (dir_q && cnt_q == i_max)       bounce_up = 1'b0;
                  else if (!dir_q && cnt_q == i_min) bounce_up = 1'b1;
                  turned = (bounce_up != dir_q);
                  if (bounce_up) begin
                     cnt_d  = up_reach ? i_max : nxt_up[W-1:0];
                     dir_d  = ~up_reach;
                     wrap_d = up_reach | turned;
                  end else begin
                     cnt_d  = dn_reach ? i_min : nxt_dn[W-1:0];
                     dir_d  = dn_reach;
                     wrap_d = dn_reach | turned;
                  end
               end
               default: begin
                  if (i_up)        cnt_d = up_over  ? i_max : nxt_up[W-1:0];
                  else if (i_down) cnt_d = dn_under ? i_min : nxt_dn[W-1:0];
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         dir_q  <= 1'b1;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_counter = cnt_q;
   assign o_wrap    = wrap_q;
   assign o_dir     = dir_q;
   assign o_high    = (cnt_q == i_max);
   assign o_low     = (cnt_q == i_min);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Scoreboard bench for prog_updown_counter: expected {count, wrap, dir}
// are queued as stimulus is driven and popped after the update edge.
module tb_prog_updown_counter;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b1;
   logic       i_en = 1'b0, i_load = 1'b0, i_up = 1'b0, i_down = 1'b0;
   logic [7:0] i_in = 8'h00, i_min = 8'h00, i_max = 8'hFF;
   logic [3:0] i_step = 4'd0;
   logic [1:0] i_mode = 2'd0;
   logic [7:0] o_counter;
   logic       o_high, o_low, o_wrap, o_dir, o_cfg_err;

   typedef struct packed {
      logic [7:0] cnt;
      logic       wrap;
      logic       dir;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   prog_updown_counter #(.DATA_WIDTH(8), .STEP_WIDTH(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_load(i_load),
      .i_in(i_in), .i_up(i_up), .i_down(i_down), .i_step(i_step),
      .i_min(i_min), .i_max(i_max), .i_mode(i_mode),
      .o_counter(o_counter), .o_high(o_high), .o_low(o_low),
      .o_wrap(o_wrap), .o_dir(o_dir), .o_cfg_err(o_cfg_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      i_en = 1'b0; i_load = 1'b1; i_in = v;
      tick();
      i_load = 1'b0;
   endtask

   task automatic test_reset();
      #2 i_rst_n = 1'b0;
      #1;
      sb.push_back('{8'h00, 1'b0, 1'b1});
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL reset_init got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok reset_init cnt=%h", o_counter);
      tick(); i_rst_n = 1'b1;
      i_mode = 2'd0; i_min = 8'h00; i_max = 8'hFF; i_step = 4'd1; i_up = 1'b1; i_en = 1'b1;
      sb.push_back('{8'h03, 1'b0, 1'b1});
      tick(); tick(); tick();
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL count3 got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok count3 cnt=%h", o_counter);
      #3 i_rst_n = 1'b0;
      #1;
      sb.push_back('{8'h00, 1'b0, 1'b1});
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL reset_mid got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok reset_mid cnt=%h", o_counter);
      i_en = 1'b0; i_up = 1'b0;
      tick(); i_rst_n = 1'b1;
   endtask

   task automatic test_load();
      i_min = 8'h10; i_max = 8'hF0;
      sb.push_back('{8'h50, 1'b0, 1'b1});
      do_load(8'h50);
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL load50 got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok load50 cnt=%h", o_counter);
      sb.push_back('{8'hF0, 1'b0, 1'b1});
      do_load(8'hFF);
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir, o_high} !== {e, 1'b1}) begin
         bad++; $display("FAIL loadFF got %h/%b/%b high=%b want %h/%b/%b high=1", o_counter, o_wrap, o_dir, o_high, e.cnt, e.wrap, e.dir);
      end else $display("ok loadFF cnt=%h high=%b", o_counter, o_high);
   endtask

   task automatic test_saturate();
      i_mode = 2'd0; i_min = 8'h00; i_max = 8'hFF;
      do_load(8'hFD);
      i_step = 4'd4; i_up = 1'b1; i_down = 1'b0; i_en = 1'b1;
      sb.push_back('{8'hFF, 1'b0, 1'b1});
      tick(); i_en = 1'b0;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir, o_high} !== {e, 1'b1}) begin
         bad++; $display("FAIL sat_up got %h/%b/%b high=%b want %h/%b/%b high=1", o_counter, o_wrap, o_dir, o_high, e.cnt, e.wrap, e.dir);
      end else $display("ok sat_up cnt=%h", o_counter);
      do_load(8'h02);
      i_step = 4'd3; i_up = 1'b0; i_down = 1'b1; i_en = 1'b1;
      sb.push_back('{8'h00, 1'b0, 1'b1});
      tick(); i_en = 1'b0; i_down = 1'b0;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir, o_low} !== {e, 1'b1}) begin
         bad++; $display("FAIL sat_dn got %h/%b/%b low=%b want %h/%b/%b low=1", o_counter, o_wrap, o_dir, o_low, e.cnt, e.wrap, e.dir);
      end else $display("ok sat_dn cnt=%h", o_counter);
   endtask

   task automatic test_wrap();
      i_mode = 2'd1; i_min = 8'h10; i_max = 8'h20;
      do_load(8'h1E);
      i_step = 4'd3; i_up = 1'b1; i_en = 1'b1;
      sb.push_back('{8'h10, 1'b1, 1'b1});
      sb.push_back('{8'h10, 1'b0, 1'b1});
      tick(); i_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e = sb.pop_front(); total++;
         if ({o_counter, o_wrap, o_dir} !== e) begin
            bad++; $display("FAIL wrap_up[%0d] got %h/%b/%b want %h/%b/%b", k, o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
         end else $display("ok wrap_up[%0d] cnt=%h wrap=%b", k, o_counter, o_wrap);
         tick();
      end
      do_load(8'h1D);
      i_en = 1'b1;
      sb.push_back('{8'h20, 1'b0, 1'b1});
      tick(); i_en = 1'b0; i_up = 1'b0;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL wrap_exact got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok wrap_exact cnt=%h", o_counter);
   endtask

   task automatic test_back_to_back_bounce();
      i_mode = 2'd2; i_min = 8'h02; i_max = 8'h08; i_step = 4'd2;
      do_load(8'h04);
      sb.push_back('{8'h06, 1'b0, 1'b1});
      sb.push_back('{8'h08, 1'b1, 1'b0});
      sb.push_back('{8'h06, 1'b0, 1'b0});
      sb.push_back('{8'h04, 1'b0, 1'b0});
      sb.push_back('{8'h02, 1'b1, 1'b1});
      sb.push_back('{8'h04, 1'b0, 1'b1});
      i_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         e = sb.pop_front(); total++;
         if ({o_counter, o_wrap, o_dir} !== e) begin
            bad++; $display("FAIL bounce[%0d] got %h/%b/%b want %h/%b/%b", k, o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
         end else $display("ok bounce[%0d] cnt=%h wrap=%b dir=%b", k, o_counter, o_wrap, o_dir);
      end
      i_en = 1'b0;
   endtask

   task automatic test_edge();
      i_mode = 2'd0; i_min = 8'h00; i_max = 8'hFF;
      do_load(8'h10);
      i_up = 1'b1; i_down = 1'b1; i_step = 4'd2; i_en = 1'b1;
      sb.push_back('{8'h12, 1'b0, 1'b1});
      sb.push_back('{8'h12, 1'b0, 1'b1});
      tick();
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL updown got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok updown cnt=%h", o_counter);
      i_step = 4'd0;
      tick();
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL step0 got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok step0 cnt=%h", o_counter);
      i_en = 1'b0; i_down = 1'b0;
      i_min = 8'h30; i_max = 8'h20;
      #1; total++;
      if (o_cfg_err !== 1'b1) begin
         bad++; $display("FAIL cfg_err got %b want 1", o_cfg_err);
      end else $display("ok cfg_err=%b", o_cfg_err);
      sb.push_back('{8'h12, 1'b0, 1'b1});
      sb.push_back('{8'h12, 1'b0, 1'b1});
      do_load(8'h55);
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL cfg_load got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok cfg_load cnt=%h", o_counter);
      i_step = 4'd1; i_en = 1'b1;
      tick(); i_en = 1'b0; i_up = 1'b0;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL cfg_en got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok cfg_en cnt=%h", o_counter);
   endtask

   task automatic test_limit_change();
      i_mode = 2'd0; i_min = 8'h00; i_max = 8'hFF;
      do_load(8'h40);
      i_max = 8'h30; i_step = 4'd1; i_up = 1'b1;
      sb.push_back('{8'h40, 1'b0, 1'b1});
      sb.push_back('{8'h30, 1'b0, 1'b1});
      tick();
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL lim_hold got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok lim_hold cnt=%h", o_counter);
      i_en = 1'b1;
      tick(); i_en = 1'b0; i_up = 1'b0;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir, o_high} !== {e, 1'b1}) begin
         bad++; $display("FAIL lim_clamp got %h/%b/%b high=%b want %h/%b/%b high=1", o_counter, o_wrap, o_dir, o_high, e.cnt, e.wrap, e.dir);
      end else $display("ok lim_clamp cnt=%h", o_counter);
   endtask

   task automatic test_reset_pulse();
      i_mode = 2'd1; i_min = 8'h10; i_max = 8'h20;
      do_load(8'h1F);
      i_step = 4'd3; i_up = 1'b1; i_en = 1'b1;
      sb.push_back('{8'h10, 1'b1, 1'b1});
      sb.push_back('{8'h00, 1'b0, 1'b1});
      tick(); i_en = 1'b0; i_up = 1'b0;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL pre_rst got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok pre_rst cnt=%h wrap=%b", o_counter, o_wrap);
      i_rst_n = 1'b0;
      #1;
      e = sb.pop_front(); total++;
      if ({o_counter, o_wrap, o_dir} !== e) begin
         bad++; $display("FAIL rst_pulse got %h/%b/%b want %h/%b/%b", o_counter, o_wrap, o_dir, e.cnt, e.wrap, e.dir);
      end else $display("ok rst_pulse cnt=%h wrap=%b", o_counter, o_wrap);
      tick(); i_rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load();
      test_saturate();
      test_wrap();
      test_back_to_back_bounce();
      test_edge();
      test_limit_change();
      test_reset_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
